// File: rtl/pin_capt_ctrl.sv
// pin_capt run sequencer: arms a capture run, timestamps strobes, buffers them in a FWFT FIFO.
// Optional dead-time filter after each counted strobe: define PIN_CAPT_CTRL_DEADTIME_EN.
module pin_capt_ctrl #(
  parameter int CW       = 16,
  parameter int DEPTH    = 8,
  parameter int NW       = 8,
  parameter int DEAD_CYC = 4
) (
  input  logic          clk300,
  input  logic          rst_n,
  input  logic          arm,
  input  logic          abort,
  input  logic [NW-1:0] num_events,
  input  logic [CW-1:0] timeout,
  input  logic          str,
  input  logic [2:0]    ptime,
  output logic [CW+2:0] ts_data,
  output logic          ts_valid,
  input  logic          ts_ready,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] ev_count,
  output logic          overflow,
  output logic          timed_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = CW + 3;
  localparam int DW = (DEAD_CYC < 1) ? 1 : $clog2(DEAD_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_coarse;
  logic [NW-1:0] r_num;
  logic [CW-1:0] r_tmo;
  logic [NW-1:0] r_ev;
  logic          r_ovf;
  logic          r_tflag;
  logic          r_busy;
  logic          r_done;
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic [TW-1:0] r_mem [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_live;
  logic          w_str;
  logic [NW-1:0] w_ev_nxt;
  logic          w_cnt_end;
  logic          w_tmo_end;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop   = !w_empty && ts_ready;
  assign w_str   = (r_state == S_RUN) && str && w_live;
  assign w_push  = w_str && (!w_full || w_pop);

  assign w_ev_nxt  = (r_ev == '1) ? r_ev : r_ev + 1'b1;
  assign w_cnt_end = w_str && (w_ev_nxt == r_num);
  assign w_tmo_end = (r_tmo != '0) && (r_coarse == r_tmo - 1'b1);

`ifdef PIN_CAPT_CTRL_DEADTIME_EN
  logic [DW-1:0] r_dead;

  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) begin
      r_dead <= '0;
    end else if (r_state == S_IDLE && arm) begin
      r_dead <= '0;
    end else if (w_str) begin
      r_dead <= DW'(DEAD_CYC);
    end else if (r_dead != '0) begin
      r_dead <= r_dead - 1'b1;
    end
  end

  assign w_live = (r_dead == '0);
`else
  logic [DW-1:0] w_dead;

  assign w_dead = '0;
  assign w_live = (w_dead == '0);
`endif

  always_ff @(posedge clk300) begin
    if (w_push) begin
      r_mem[r_wp[AW-1:0]] <= {r_coarse, ptime};
    end
  end

  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (abort) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_coarse <= '0;
      r_num    <= '0;
      r_tmo    <= '0;
      r_ev     <= '0;
      r_ovf    <= 1'b0;
      r_tflag  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (arm) begin
            r_num    <= num_events;
            r_tmo    <= timeout;
            r_coarse <= '0;
            r_ev     <= '0;
            r_ovf    <= 1'b0;
            r_tflag  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= (num_events == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          r_coarse <= r_coarse + 1'b1;
          if (w_str) r_ev <= w_ev_nxt;
          if (w_str && !w_push) r_ovf <= 1'b1;
          // count end takes precedence over a coincident timeout
          if (w_cnt_end) begin
            r_state <= S_DRAIN;
          end else if (w_tmo_end) begin
            r_tflag <= 1'b1;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ts_valid  = !w_empty;
  assign ts_data   = w_empty ? '0 : r_mem[r_rp[AW-1:0]];
  assign busy      = r_busy;
  assign done      = r_done;
  assign ev_count  = r_ev;
  assign overflow  = r_ovf;
  assign timed_out = r_tflag;

endmodule

// File: tb/tb_pin_capt_ctrl.sv
// Directed bench for pin_capt_ctrl with a timestamp scoreboard.
// Dead-time scenario only runs when PIN_CAPT_CTRL_DEADTIME_EN is defined.
module tb_pin_capt_ctrl;

  localparam int CW    = 16;
  localparam int DEPTH = 8;
  localparam int NW    = 8;
  localparam int TW    = CW + 3;

  logic          clk300 = 1'b0;
  logic          rst_n;
  logic          arm;
  logic          abort;
  logic [NW-1:0] num_events;
  logic [CW-1:0] timeout;
  logic          str;
  logic [2:0]    ptime;
  logic [TW-1:0] ts_data;
  logic          ts_valid;
  logic          ts_ready;
  logic          busy;
  logic          done;
  logic [NW-1:0] ev_count;
  logic          overflow;
  logic          timed_out;

  pin_capt_ctrl #(
    .CW(CW), .DEPTH(DEPTH), .NW(NW), .DEAD_CYC(4)
  ) dut (
    .clk300     (clk300),
    .rst_n      (rst_n),
    .arm        (arm),
    .abort      (abort),
    .num_events (num_events),
    .timeout    (timeout),
    .str        (str),
    .ptime      (ptime),
    .ts_data    (ts_data),
    .ts_valid   (ts_valid),
    .ts_ready   (ts_ready),
    .busy       (busy),
    .done       (done),
    .ev_count   (ev_count),
    .overflow   (overflow),
    .timed_out  (timed_out)
  );

  always #5 clk300 = ~clk300;

  int            n_chk = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  logic [TW-1:0] sb [$];
  bit            m_run = 1'b0;
  bit            m_acc = 1'b1;
  logic [CW-1:0] m_coarse = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    bit            pop;
    bit            push;
    logic [TW-1:0] d;
    logic [TW-1:0] d2;
    @(negedge clk300);
    if (done) done_cnt++;
    chk("ts_valid", {31'd0, ts_valid}, {31'd0, sb.size() != 0});
    pop = (sb.size() != 0) && ts_ready;
    if (pop) chk("ts_data", 32'(ts_data), 32'(sb[0]));
    push = m_run && str && m_acc &&
           ((sb.size() < DEPTH) || pop);
    d = {m_coarse, ptime};
    @(posedge clk300);
    if (pop) d2 = sb.pop_front();
    if (push) sb.push_back(d);
    if (m_run) m_coarse++;
    #1;
  endtask

  task automatic arm_run(input logic [NW-1:0] n, input logic [CW-1:0] t);
    num_events = n;
    timeout    = t;
    arm        = 1'b1;
    done_cnt   = 0;
    tick();
    arm      = 1'b0;
    m_run    = (n != 0);
    m_coarse = '0;
    m_acc    = 1'b1;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && done_cnt == 0; i++) tick();
    chk("done_seen", done_cnt, 1);
    tick();
    tick();
    chk("done_once", done_cnt, 1);
    chk("busy_idle", {31'd0, busy}, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; arm = 0; abort = 0; str = 0; ptime = 0;
    ts_ready = 0; num_events = 0; timeout = 0;
    repeat (3) @(posedge clk300);
    #1;
    chk("rst_valid", {31'd0, ts_valid}, 0);
    chk("rst_data", 32'(ts_data), 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ev", 32'(ev_count), 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_tmo", {31'd0, timed_out}, 0);
    @(negedge clk300);
    rst_n = 1'b1;
    @(posedge clk300);
    #1;

    // basic run with three strobes
    ts_ready = 1;
    arm_run(3, 0);
    chk("t1_busy", {31'd0, busy}, 1);
    for (int c = 0; c < 15; c++) begin
      str   = (c == 5) || (c == 9) || (c == 14);
      ptime = (c == 5) ? 3'd2 : (c == 9) ? 3'd7 : 3'd0;
      tick();
    end
    str = 0; m_run = 0;
    chk("t1_ev", 32'(ev_count), 3);
    wait_done(20);

    // strobe while idle is ignored
    str = 1; ptime = 3;
    tick();
    str = 0;
    chk("idle_ev", 32'(ev_count), 3);

    // zero events goes straight to drain
    arm_run(0, 0);
    chk("z_busy", {31'd0, busy}, 1);
    wait_done(5);
    chk("z_ev", 32'(ev_count), 0);

    // overflow with stalled consumer
    ts_ready = 0;
    arm_run(12, 0);
    for (int c = 0; c < 12; c++) begin
      str = 1; ptime = 3'(c);
      tick();
    end
    str = 0; m_run = 0;
    chk("t2_ovf", {31'd0, overflow}, 1);
    chk("t2_ev", 32'(ev_count), 12);
    chk("t2_busy", {31'd0, busy}, 1);
    ts_ready = 1;
    wait_done(30);

    // timeout ends the run
    ts_ready = 0;
    arm_run(10, 20);
    chk("t3_ovf_clr", {31'd0, overflow}, 0);
    for (int c = 0; c < 20; c++) begin
      str   = (c == 3) || (c == 7);
      ptime = (c == 3) ? 3'd1 : 3'd4;
      if (c == 19) chk("t3_tmo_pre", {31'd0, timed_out}, 0);
      tick();
    end
    str = 0; m_run = 0;
    chk("t3_tmo", {31'd0, timed_out}, 1);
    chk("t3_busy", {31'd0, busy}, 1);
    chk("t3_ev", 32'(ev_count), 2);
    ts_ready = 1;
    wait_done(20);
    chk("t3_tmo_hold", {31'd0, timed_out}, 1);

    // count end coincides with timeout
    arm_run(2, 10);
    for (int c = 0; c < 10; c++) begin
      str   = (c == 4) || (c == 9);
      ptime = (c == 4) ? 3'd6 : 3'd3;
      tick();
    end
    str = 0; m_run = 0;
    chk("t4_tmo", {31'd0, timed_out}, 0);
    chk("t4_ev", 32'(ev_count), 2);
    chk("t4_busy", {31'd0, busy}, 1);
    wait_done(20);

    // abort with buffered entries
    ts_ready = 0;
    arm_run(10, 0);
    for (int c = 0; c < 6; c++) begin
      str = (c >= 1) && (c <= 3); ptime = 3'(c);
      tick();
    end
    str = 0;
    abort = 1;
    tick();
    abort = 0; m_run = 0;
    sb.delete();
    chk("t5_valid", {31'd0, ts_valid}, 0);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_ev", 32'(ev_count), 3);
    chk("t5_nodone", done_cnt, 0);
    arm_run(1, 0);
    chk("t5_rearm", {31'd0, busy}, 1);
    ts_ready = 1; str = 1; ptime = 5;
    tick();
    str = 0; m_run = 0;
    wait_done(10);
    chk("t5_ev2", 32'(ev_count), 1);

`ifdef PIN_CAPT_CTRL_DEADTIME_EN
    // dead time suppresses strobes at 2 and 6
    ts_ready = 0;
    arm_run(4, 10);
    for (int c = 0; c < 10; c++) begin
      str   = (c == 0) || (c == 2) || (c == 5) || (c == 6);
      m_acc = !((c == 2) || (c == 6));
      ptime = 3'(c);
      tick();
    end
    str = 0; m_run = 0; m_acc = 1;
    chk("t6_ev", 32'(ev_count), 2);
    chk("t6_ovf", {31'd0, overflow}, 0);
    chk("t6_tmo", {31'd0, timed_out}, 1);
    ts_ready = 1;
    wait_done(20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
